// File: rtl/ssd_scan_ctrl_if.sv
// Signal bundle between the seven-segment scan scheduler and the logic that
// supplies the digit values. clk/rst stay as plain ports on the modules.
interface ssd_scan_ctrl_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  ssd_ctl;
    logic [7:0]  segs;
    logic [1:0]  digit_idx;
    logic        frame_start;

    // Value source side: supplies digits and controls, observes the display drive
    modport master (
        output en,
        output digits,
        output dp_mask,
        output lz_blank,
        input  ssd_ctl,
        input  segs,
        input  digit_idx,
        input  frame_start
    );

    // Scheduler side
    modport slave (
        input  en,
        input  digits,
        input  dp_mask,
        input  lz_blank,
        output ssd_ctl,
        output segs,
        output digit_idx,
        output frame_start
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan scheduler.
// Rotates one active-low segment bus over four active-low digit enables,
// opening each slot with a dark guard interval against ghosting. Digit
// values are snapshotted once per frame so a frame never mixes old and new
// data. BCD decode, decimal points and leading-zero blanking happen here.
// All outputs are registered and reflect the state entered on the last edge.
module ssd_scan_ctrl #(
    parameter int unsigned SCAN_PERIOD  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    ssd_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_PERIOD);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam bit HAS_GUARD = (BLANK_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ON
    } state_t;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
    } snap_t;

    // Registered state
    state_t           state_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    snap_t            snap_q;
    logic [3:0]       ctl_q;
    logic [7:0]       segs_q;
    logic             fs_q;

    // Next-state values
    state_t           state_d;
    logic [1:0]       idx_d;
    logic [CNT_W-1:0] cnt_d;
    snap_t            snap_d;
    logic [3:0]       ctl_d;
    logic [7:0]       segs_d;
    logic             fs_d;

    snap_t            live;

    // Decode helpers
    logic [3:0]       nib;
    logic             blank;
    logic             z3;
    logic             z32;
    logic             z321;
    logic [6:0]       seg_on;

    // Active-low a..g pattern for one nibble; 10..15 show "F"
    function automatic logic [6:0] decode7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign live = {bus.digits, bus.dp_mask, bus.lz_blank};

    // Slot scheduler: next state, slot counter, digit index and frame snapshot
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;

        if (!bus.en) begin
            // Enable drop wins over any slot-end event on the same edge
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    snap_d  = live;
                    fs_d    = 1'b1;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = HAS_GUARD ? GUARD : ON;
                end
                GUARD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GUARD_LAST) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = HAS_GUARD ? GUARD : ON;
                        if (idx_q == 2'd3) begin
                            snap_d = live;
                            fs_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Display drive for the state being entered; decoded from next-state values
    // so the registered outputs line up with the registered state
    always_comb begin
        z3   = (snap_d.digits[15:12] == 4'd0);
        z32  = z3  && (snap_d.digits[11:8] == 4'd0);
        z321 = z32 && (snap_d.digits[7:4]  == 4'd0);

        nib   = 4'd0;
        blank = 1'b0;
        case (idx_d)
            2'd0: begin
                nib   = snap_d.digits[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = snap_d.digits[7:4];
                blank = snap_d.lz && z321;
            end
            2'd2: begin
                nib   = snap_d.digits[11:8];
                blank = snap_d.lz && z32;
            end
            default: begin
                nib   = snap_d.digits[15:12];
                blank = snap_d.lz && z3;
            end
        endcase

        seg_on = blank ? 7'h7F : decode7(nib);

        ctl_d  = 4'hF;
        segs_d = 8'hFF;
        if (state_d == ON) begin
            ctl_d  = ~(4'b0001 << idx_d);
            segs_d = {seg_on, ~snap_d.dp[idx_d]};
        end
    end

    // State and output registers with asynchronous reset to a dark display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= '0;
            ctl_q   <= 4'hF;
            segs_q  <= 8'hFF;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            ctl_q   <= ctl_d;
            segs_q  <= segs_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.ssd_ctl     = ctl_q;
    assign bus.segs        = segs_q;
    assign bus.digit_idx   = idx_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with SCAN_PERIOD=8, BLANK_CYCLES=2.
// Expected per-cycle output vectors {ssd_ctl, segs, digit_idx, frame_start}
// are queued when stimulus is set up and compared at each falling edge.
module tb_ssd_scan_ctrl;

    localparam int SP = 8;
    localparam int BC = 2;

    typedef logic [14:0] exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    exp_t sb[$];
    exp_t obs;
    exp_t exp_v;

    ssd_scan_ctrl_if bus ();

    ssd_scan_ctrl #(
        .SCAN_PERIOD (SP),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign obs = {bus.ssd_ctl, bus.segs, bus.digit_idx, bus.frame_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spec decode table, active-low with dp bit = 1
    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    return 8'b00000011;
            4'd1:    return 8'b10011111;
            4'd2:    return 8'b00100101;
            4'd3:    return 8'b00001101;
            4'd4:    return 8'b10011001;
            4'd5:    return 8'b01001001;
            4'd6:    return 8'b01000001;
            4'd7:    return 8'b00011111;
            4'd8:    return 8'b00000001;
            4'd9:    return 8'b00001001;
            default: return 8'b01110001;
        endcase
    endfunction

    // Lit-digit vector: a non-zero digit is blanked when it and everything above it is zero
    function automatic exp_t on_entry(input logic [15:0] dig, input logic [3:0] dp,
                                      input logic lz, input int d);
        logic [15:0] upper;
        logic [7:0]  code;
        logic [3:0]  ctl;
        logic [1:0]  di;
        upper   = dig >> (4 * d);
        code    = (lz && d != 0 && upper == 16'h0000) ? 8'hFF : seg_code(upper[3:0]);
        code[0] = ~dp[d];
        ctl     = 4'hF & ~(4'b0001 << d);
        di      = d[1:0];
        return {ctl, code, di, 1'b0};
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("ctl=%b segs=%b idx=%0d fs=%b", v[14:11], v[10:3], v[2:1], v[0]);
    endfunction

    // Queue the first n cycles of a frame that starts on the next edge
    task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp,
                              input logic lz, input int n);
        for (int k = 0; k < n; k++) begin
            int d;
            int c;
            d = k / SP;
            c = k % SP;
            if (c < BC) sb.push_back({4'hF, 8'hFF, 2'(d), (c == 0 && d == 0)});
            else        sb.push_back(on_entry(dig, dp, lz, d));
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.digits   = 16'h1234;
        bus.dp_mask  = 4'b0000;
        bus.lz_blank = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL reset_hold: got %s, want %s", fmt(obs), fmt(exp_v));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        push_frame(16'h1234, 4'b0000, 1'b0, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL scan cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    task automatic test_snapshot();
        push_frame(16'h1234, 4'b0000, 1'b0, 4 * SP);
        push_frame(16'h5678, 4'b0000, 1'b0, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL snapshot cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
            if (i == SP + 1) bus.digits = 16'h5678;
        end
    endtask

    task automatic test_lz_blank();
        bus.lz_blank = 1'b1;
        bus.digits   = 16'h0050;
        push_frame(16'h0050, 4'b0000, 1'b1, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL lz_0050 cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
        bus.digits = 16'h0000;
        push_frame(16'h0000, 4'b0000, 1'b1, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL lz_0000 cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    task automatic test_dp_hex();
        bus.lz_blank = 1'b0;
        bus.digits   = 16'h000A;
        bus.dp_mask  = 4'b0001;
        push_frame(16'h000A, 4'b0001, 1'b0, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL dp_hex cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    task automatic test_en_drop();
        bus.digits  = 16'h9876;
        bus.dp_mask = 4'b1010;
        // Through the second ON cycle of digit 2
        push_frame(16'h9876, 4'b1010, 1'b0, 2 * SP + BC + 2);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL en_pre_drop cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
        bus.en       = 1'b0;
        bus.digits   = 16'h0321;
        bus.dp_mask  = 4'b1000;
        bus.lz_blank = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL en_low cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
        bus.en = 1'b1;
        push_frame(16'h0321, 4'b1000, 1'b1, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL en_restart cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    task automatic test_async_reset();
        bus.digits   = 16'h1234;
        bus.dp_mask  = 4'b0000;
        bus.lz_blank = 1'b0;
        // Into the ON phase of digit 1
        push_frame(16'h1234, 4'b0000, 1'b0, SP + BC + 2);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL pre_reset cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
        #1 rst = 1'b1;
        #1;
        sb.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL async_reset: got %s, want %s", fmt(obs), fmt(exp_v));
        end
        @(negedge clk);
        rst = 1'b0;
        push_frame(16'h1234, 4'b0000, 1'b0, 4 * SP);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL post_reset cycle %0d: got %s, want %s", i, fmt(obs), fmt(exp_v));
            end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_scan();
        test_snapshot();
        test_lz_blank();
        test_dp_hex();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scheduler for the 4-digit, common-anode seven-segment display. It shares one active-low segment bus among four digit enables, rotating digits 0..3 at a fixed slot period. Each slot starts with a ghosting guard interval. A per-frame snapshot of the digit values prevents tearing. Per-digit decode, decimal point and leading-zero blanking are applied inside the block.

Parameters:
SCAN_PERIOD, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2
BLANK_CYCLES, 1000, guard cycles at the start of each slot with all digits off; legal range 0 <= BLANK_CYCLES < SCAN_PERIOD

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; low = display dark
digits  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
dp_mask  input  4  decimal-point request per digit; bit n = digit n
lz_blank  input  1  leading-zero suppression enable
ssd_ctl  output  4  digit enables, active-low; digit n driven by bit n = 0
segs  output  8  segments, active-low, {a,b,c,d,e,f,g,dp}
digit_idx  output  2  index of the current slot
frame_start  output  1  one-cycle pulse on the edge that latches the snapshot

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Output registering: all outputs are registered. The values below are the register contents after the stated edge.
- Reset (asynchronous, including mid-slot):
  - state = IDLE, idx = 0, slot_cnt = 0, snapshot = 0.
  - ssd_ctl = 4'b1111, segs = 8'hFF, digit_idx = 0, frame_start = 0.
- States: IDLE, GUARD, ON.
- IDLE:
  - Outputs are dark (as at reset).
  - On an edge with en = 1: latch snapshot <= {digits, dp_mask, lz_blank}, frame_start = 1, idx = 0, slot_cnt = 0.
  - Next state is GUARD, or ON if BLANK_CYCLES = 0.
- GUARD:
  - ssd_ctl = 1111, segs = FF.
  - slot_cnt increments each cycle.
  - On the edge where slot_cnt == BLANK_CYCLES-1, go to ON.
- ON:
  - ssd_ctl has only bit idx low; segs = decode(idx).
  - slot_cnt continues to increment.
  - On the edge where slot_cnt == SCAN_PERIOD-1: slot_cnt = 0 and idx = idx+1, wrapping 3 -> 0. Next state is GUARD, or ON if BLANK_CYCLES = 0.
- Slot timing: each slot is exactly SCAN_PERIOD cycles, of which BLANK_CYCLES are dark. Digit order is 0, 1, 2, 3, 0, ...
- Frame snapshot: when idx wraps 3 -> 0, the snapshot is re-latched and frame_start pulses for one cycle. Input changes at any other time are invisible until that point.
- Enable drop: en = 0 in any state forces the next edge to IDLE and all outputs dark, with idx = 0 and slot_cnt = 0. en has priority over slot-end events on the same edge.
- Decode of nibble v (active-low, dp bit = 1):
  - 0: 00000011
  - 1: 10011111
  - 2: 00100101
  - 3: 00001101
  - 4: 10011001
  - 5: 01001001
  - 6: 01000001
  - 7: 00011111
  - 8: 00000001
  - 9: 00001001
  - 10..15: 01110001 ("F")
- Leading-zero blanking (when snapshot lz_blank = 1):
  - Digit 3 is blanked if nib3 == 0.
  - Digit 2 is blanked if nib3 and nib2 are both 0.
  - Digit 1 is blanked if nib3, nib2 and nib1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives segs[7:1] = 7'h7F.
- Decimal point: segs[0] = ~dp_mask[idx] from the snapshot. This applies even when the digit is blanked.
- digit_idx: equals idx in every state (0 in IDLE).

Test Plan:
(Run with SCAN_PERIOD=8, BLANK_CYCLES=2.)
1. Hold rst = 1, en = 1 -> ssd_ctl = 1111, segs = FF, frame_start = 0. Assert rst mid-ON -> outputs go dark immediately, without waiting for a clock edge.
2. Release reset; en = 1, digits = 16'h1234, dp_mask = 0, lz_blank = 0 -> the following occur in order:
   - frame_start pulses for 1 cycle.
   - Dark for 2 cycles.
   - ssd_ctl = 1110, segs = 10011001 for 6 cycles.
   - Dark for 2 cycles.
   - ssd_ctl = 1101, segs = 00001101 for 6 cycles.
   - Digits 2 and 3 follow the same pattern with SS_2 and SS_1.
   - The sequence then wraps to digit 0 with frame_start = 1.
3. Change digits to 16'h5678 during digit 1's slot -> digits 2 and 3 still show 2 and 1. Digit 0 of the next frame shows SS_8 (00000001).
4. lz_blank = 1, digits = 16'h0050 -> digits 3 and 2 show segs = FF while ssd_ctl is active; digit 1 = 01001001; digit 0 = 00000011. With digits = 16'h0000, only digit 0 shows 00000011.
5. digits = 16'h000A, dp_mask = 4'b0001, lz_blank = 0 -> digit 0 segs = 01110000; digits 1..3 segs = 00000011.
6. Drop en during an ON cycle of digit 2 -> the next edge gives dark outputs and digit_idx = 0. Re-raise en -> frame_start pulses and scanning restarts at digit 0 with a 2-cycle guard.
